// File: rtl/stream_compose02_pkg.sv
// Shared types for stream_compose02: FSM state encoding, widths, acceptance helper.
// Optional skid buffer is selected with STREAM_COMPOSE_SKID_EN.
package stream_compose02_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EMIT0 = 2'd1,
    ST_EMIT1 = 2'd2,
    ST_PASS  = 2'd3
  } state_t;

  localparam int DEFAULT_N  = 8;
  localparam int SKID_DEPTH = 2;

  // A new call may start only from a resting state with no unacknowledged completion.
  function automatic logic call_open(input state_t st, input logic pend);
    return ((st == ST_IDLE) || (st == ST_PASS)) && !pend;
  endfunction

endpackage

// File: rtl/stream_compose02_skid_buf.sv
// Two-entry registered skid buffer for the composed output stream.
// Only instantiated when STREAM_COMPOSE_SKID_EN is defined.
module stream_compose02_skid_buf
  import stream_compose02_pkg::*;
#(
  parameter int W = DEFAULT_N
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic [W-1:0] push_data,
  input  logic         push_valid,
  output logic         push_ready,
  output logic [W-1:0] pop_data,
  output logic         pop_valid,
  input  logic         pop_ready
);

  logic [W-1:0] mem [SKID_DEPTH];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;
  logic         push;
  logic         pop;

  assign push_ready = (count != 2'd2);
  assign pop_valid  = (count != 2'd0);
  assign pop_data   = mem[rd_ptr];
  assign push       = push_valid & push_ready;
  assign pop        = pop_valid & pop_ready;

  // Entries are cleared on reset so the output data reads zero while empty.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      for (int i = 0; i < SKID_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/stream_compose02.sv
// Stream composer: emits latched v0, then v1, then forwards the tail stream unchanged.
// Define STREAM_COMPOSE_SKID_EN to register the output path through a 2-entry skid buffer.
module stream_compose02
  import stream_compose02_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         in_valid,
  output logic         in_ready,
  output logic         out_valid,
  input  logic         out_ready,
  input  logic [N-1:0] v0,
  input  logic [N-1:0] v1,
  input  logic [N-1:0] t,
  input  logic         t_valid,
  output logic         t_ready,
  output logic [N-1:0] s,
  output logic         s_valid,
  input  logic         s_ready
);

  state_t       state;
  logic [N-1:0] v0_lat;
  logic [N-1:0] v1_lat;
  logic         out_pend;
  logic [N-1:0] core_s;
  logic         core_valid;
  logic         core_ready;
  logic         core_xfer;
  logic         accept;

  assign in_ready  = call_open(state, out_pend);
  assign accept    = in_valid & in_ready;
  assign out_valid = out_pend;
  assign core_xfer = core_valid & core_ready;
  // Tail is only ever consumed while passing through; a tail beat taken on the
  // accepting edge is already on s in that cycle, so nothing is lost at the cut.
  assign t_ready   = (state == ST_PASS) & core_ready;

  always_comb begin
    core_s     = '0;
    core_valid = 1'b0;
    case (state)
      ST_EMIT0: begin
        core_s     = v0_lat;
        core_valid = 1'b1;
      end
      ST_EMIT1: begin
        core_s     = v1_lat;
        core_valid = 1'b1;
      end
      ST_PASS: begin
        core_s     = t;
        core_valid = t_valid;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state    <= ST_IDLE;
      v0_lat   <= '0;
      v1_lat   <= '0;
      out_pend <= 1'b0;
    end else begin
      if (out_pend && out_ready) out_pend <= 1'b0;
      case (state)
        ST_IDLE, ST_PASS: begin
          if (accept) begin
            v0_lat <= v0;
            v1_lat <= v1;
            state  <= ST_EMIT0;
          end
        end
        ST_EMIT0: begin
          if (core_xfer) state <= ST_EMIT1;
        end
        ST_EMIT1: begin
          // Completion is registered, so it is visible for at least one cycle.
          if (core_xfer) begin
            state    <= ST_PASS;
            out_pend <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef STREAM_COMPOSE_SKID_EN
  stream_compose02_skid_buf #(
    .W(N)
  ) u_skid (
    .clk       (clk),
    .nrst      (nrst),
    .push_data (core_s),
    .push_valid(core_valid),
    .push_ready(core_ready),
    .pop_data  (s),
    .pop_valid (s_valid),
    .pop_ready (s_ready)
  );
`else
  assign s          = core_s;
  assign s_valid    = core_valid;
  assign core_ready = s_ready;
`endif

endmodule

// File: tb/tb_stream_compose02.sv
// Self-checking bench for stream_compose02: cycle table plus an ordering scoreboard on s.
module tb_stream_compose02;

  logic       clk = 1'b0;
  logic       nrst;
  logic       in_valid;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] v0;
  logic [7:0] v1;
  logic [7:0] t;
  logic       t_valid;
  logic       t_ready;
  logic [7:0] s;
  logic       s_valid;
  logic       s_ready;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] sb_q [$];

  always #5 clk = ~clk;

  stream_compose02 #(.N(8)) dut (
    .clk      (clk),
    .nrst     (nrst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .v0       (v0),
    .v1       (v1),
    .t        (t),
    .t_valid  (t_valid),
    .t_ready  (t_ready),
    .s        (s),
    .s_valid  (s_valid),
    .s_ready  (s_ready)
  );

  typedef struct {
    logic       iv;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] tt;
    logic       tv;
    logic       sr;
    logic       orr;
    logic       e_sv;
    logic [7:0] e_s;
    logic       e_tr;
    logic       e_ir;
    logic       e_ov;
  } vec_t;

  vec_t tbl [18];

  function automatic vec_t mk(input logic iv, input logic [7:0] a, b, tt,
                              input logic tv, sr, orr, e_sv,
                              input logic [7:0] e_s, input logic e_tr, e_ir, e_ov);
    vec_t r;
    r.iv = iv; r.a = a; r.b = b; r.tt = tt; r.tv = tv; r.sr = sr; r.orr = orr;
    r.e_sv = e_sv; r.e_s = e_s; r.e_tr = e_tr; r.e_ir = e_ir; r.e_ov = e_ov;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference ordering: tail beats taken, then a newly accepted prefix, must leave s in that order.
  initial begin
    forever begin
      @(posedge clk);
      if (!nrst) begin
        sb_q.delete();
      end else begin
        if (t_valid && t_ready) sb_q.push_back(t);
        if (in_valid && in_ready) begin
          sb_q.push_back(v0);
          sb_q.push_back(v1);
        end
        if (s_valid && s_ready) begin
          if (sb_q.size() == 0) begin
            check("sb_unexpected_s", {24'd0, s}, 32'hFFFF_FFFF);
          end else begin
            logic [7:0] e;
            e = sb_q.pop_front();
            $display("xfer s=%02h expected=%02h", s, e);
            check("sb_order", {24'd0, s}, {24'd0, e});
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic take_t;
    logic take_c;
    int   calls_acc;

    nrst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; v0 = '0; v1 = '0;
    t = '0; t_valid = 1'b0; s_ready = 1'b1;
    // Cycle-by-cycle vectors; each row's expectations are for the cycle it is driven in.
    tbl[0]  = mk(1, 8'h05, 8'h09, 8'h01, 1, 1, 1,  0, 8'h00, 0, 1, 0);
    tbl[1]  = mk(0, 8'h00, 8'h00, 8'h01, 1, 1, 1,  1, 8'h05, 0, 0, 0);
    tbl[2]  = mk(0, 8'h00, 8'h00, 8'h01, 1, 1, 1,  1, 8'h09, 0, 0, 0);
    tbl[3]  = mk(0, 8'h00, 8'h00, 8'h01, 1, 1, 1,  1, 8'h01, 1, 0, 1);
    tbl[4]  = mk(0, 8'h00, 8'h00, 8'h02, 1, 1, 1,  1, 8'h02, 1, 1, 0);
    tbl[5]  = mk(0, 8'h00, 8'h00, 8'h03, 1, 1, 1,  1, 8'h03, 1, 1, 0);
    tbl[6]  = mk(0, 8'h00, 8'h00, 8'h77, 0, 1, 1,  0, 8'h77, 1, 1, 0);
    tbl[7]  = mk(0, 8'h00, 8'h00, 8'h04, 1, 1, 1,  1, 8'h04, 1, 1, 0);
    tbl[8]  = mk(1, 8'h05, 8'h09, 8'h05, 1, 1, 1,  1, 8'h05, 1, 1, 0);
    tbl[9]  = mk(0, 8'h00, 8'h00, 8'h06, 1, 0, 1,  1, 8'h05, 0, 0, 0);
    tbl[10] = mk(0, 8'h00, 8'h00, 8'h06, 1, 0, 1,  1, 8'h05, 0, 0, 0);
    tbl[11] = mk(0, 8'h00, 8'h00, 8'h06, 1, 0, 1,  1, 8'h05, 0, 0, 0);
    tbl[12] = mk(0, 8'h00, 8'h00, 8'h06, 1, 1, 1,  1, 8'h05, 0, 0, 0);
    tbl[13] = mk(0, 8'h00, 8'h00, 8'h06, 1, 1, 0,  1, 8'h09, 0, 0, 0);
    tbl[14] = mk(1, 8'h11, 8'h22, 8'h06, 1, 1, 0,  1, 8'h06, 1, 0, 1);
    tbl[15] = mk(1, 8'h11, 8'h22, 8'h07, 1, 1, 0,  1, 8'h07, 1, 0, 1);
    tbl[16] = mk(0, 8'h00, 8'h00, 8'h08, 1, 1, 1,  1, 8'h08, 1, 0, 1);
    tbl[17] = mk(0, 8'h00, 8'h00, 8'h09, 1, 1, 1,  1, 8'h09, 1, 1, 0);

    repeat (3) @(posedge clk);
    #1 nrst = 1'b1;
    @(negedge clk);
    check("rst_s_valid",   {31'd0, s_valid},   32'd0);
    check("rst_s",         {24'd0, s},         32'd0);
    check("rst_t_ready",   {31'd0, t_ready},   32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready",  {31'd0, in_ready},  32'd1);

    for (int i = 0; i < 18; i++) begin
      @(posedge clk); #1;
      in_valid = tbl[i].iv; v0 = tbl[i].a; v1 = tbl[i].b; t = tbl[i].tt;
      t_valid = tbl[i].tv; s_ready = tbl[i].sr; out_ready = tbl[i].orr;
      @(negedge clk);
      check($sformatf("row%0d_s_valid", i),   {31'd0, s_valid},   {31'd0, tbl[i].e_sv});
      check($sformatf("row%0d_s", i),         {24'd0, s},         {24'd0, tbl[i].e_s});
      check($sformatf("row%0d_t_ready", i),   {31'd0, t_ready},   {31'd0, tbl[i].e_tr});
      check($sformatf("row%0d_in_ready", i),  {31'd0, in_ready},  {31'd0, tbl[i].e_ir});
      check($sformatf("row%0d_out_valid", i), {31'd0, out_valid}, {31'd0, tbl[i].e_ov});
    end

    // Random back-pressure with counting tail and two calls landing in pass-through.
    take_t = 1'b0; take_c = 1'b0; calls_acc = 0;
    t = 8'h20; in_valid = 1'b0; out_ready = 1'b1;
    for (int cyc = 0; cyc < 80; cyc++) begin
      @(posedge clk); #1;
      if (take_t) t = t + 8'd1;
      if (take_c) begin
        in_valid = 1'b0;
        calls_acc++;
      end
      if (cyc == 10) begin in_valid = 1'b1; v0 = 8'hAA; v1 = 8'h55; end
      if (cyc == 40) begin in_valid = 1'b1; v0 = 8'h3C; v1 = 8'hC3; end
      t_valid = ($urandom_range(0, 3) != 0);
      s_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      take_t = t_valid && t_ready;
      take_c = in_valid && in_ready;
    end
    @(posedge clk); #1;
    if (take_c) calls_acc++;
    in_valid = 1'b0; t_valid = 1'b0; s_ready = 1'b1;
    check("calls_accepted", calls_acc, 32'd2);
    for (int k = 0; k < 20; k++) begin
      if (sb_q.size() == 0) break;
      @(posedge clk); #1;
    end
    check("drain_empty", sb_q.size(), 32'd0);

    // Reset while holding v1 in EMIT1.
    @(posedge clk); #1;
    in_valid = 1'b1; v0 = 8'h12; v1 = 8'h34; s_ready = 1'b1; t_valid = 1'b0;
    @(negedge clk);
    check("call_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("lat1_s_valid", {31'd0, s_valid}, 32'd1);
    check("lat1_s",       {24'd0, s},       32'h12);
    @(posedge clk); #1;
    s_ready = 1'b0; nrst = 1'b0;
    @(negedge clk);
    check("emit1_s",       {24'd0, s},       32'h34);
    check("emit1_s_valid", {31'd0, s_valid}, 32'd1);
    @(posedge clk); #1;
    nrst = 1'b1; t_valid = 1'b1; t = 8'h66; s_ready = 1'b1;
    @(negedge clk);
    check("post_rst_s_valid",   {31'd0, s_valid},   32'd0);
    check("post_rst_s",         {24'd0, s},         32'd0);
    check("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("post_rst_in_ready",  {31'd0, in_ready},  32'd1);
    check("post_rst_t_ready",   {31'd0, t_ready},   32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("idle_hold_s_valid", {31'd0, s_valid}, 32'd0);
    check("idle_hold_t_ready", {31'd0, t_ready}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
